bkram_sd_ctrl: RTL and testbench

//  Sequences save-RAM backup between the 8 KiB on-chip nvram dpram (port B) and the SD image via user_io.

---
 rtl/bkram_pkg.sv | 33 +++
 rtl/bkram_sd_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_bkram_sd_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bkram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bkram_pkg
//  Description : Shared types and constants for the save-RAM backup
//                controller (bkram_sd_ctrl).
//                  state_t - block-transfer sequencer states
//                  op_t    - direction of the current sequence
//                  BLK_SZ  - SD block size in bytes
//                  blk_count() - number of blocks covered for a given BLK_W
//  Revision    : 1.0 - initial release
// ============================================================================
package bkram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // waiting for a pending load or save
        REQ  = 2'd1,   // sd_rd/sd_wr held until user_io acknowledges
        XFER = 2'd2    // block moving, waiting for sd_ack to drop
    } state_t;

    typedef enum logic {
        OP_LOAD = 1'b0,   // SD image -> nvram
        OP_SAVE = 1'b1    // nvram -> SD image
    } op_t;

    localparam int BLK_SZ = 512;

    // Number of blocks in a full backup for a given block-address width.
    function automatic int blk_count(input int blk_w);
        return 1 << blk_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bkram_sd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bkram_sd_ctrl
//  Description : Sequences save-RAM backup between the on-chip nvram dpram
//                (port B) and the mounted SD image through user_io.
//                A full load of all 2**BLK_W blocks runs when a non-empty
//                image is mounted; a full save runs on an OSD save request.
//                bk_reset pulses for one cycle after every completed load so
//                the core restarts with the freshly loaded save data.
//                The dpram port B address {sd_lba[BLK_W-1:0], sd_buff_addr}
//                is formed at the top level, not here.
//
//  Ports       : clk_sys        in   system clock
//                RESET_n        in   synchronous active-low reset (PLL lock)
//                img_mounted    in   user_io image-mounted strobe/level
//                img_size       in   mounted image size in bytes
//                ioctl_download in   ROM download in progress
//                bk_save        in   OSD "Write Save RAM" level
//                nvram_we       in   core write to nvram (autosave only)
//                sd_ack         in   user_io block transfer acknowledge
//                sd_lba         out  block address (upper bits always 0)
//                sd_rd          out  block read request
//                sd_wr          out  block write request
//                bk_ena         out  valid save image mounted
//                bk_busy        out  transfer sequence active
//                bk_reset       out  one-cycle pulse after a full load
//
//  Options     : BKRAM_AUTOSAVE_EN - when defined, core writes to nvram mark
//                the save RAM dirty and a save is issued automatically after
//                IDLE_CYCLES of write-free idle time.
//  Revision    : 1.0 - initial release
// ============================================================================
module bkram_sd_ctrl
    import bkram_pkg::*;
#(
    parameter int          BLK_W       = 4,
    parameter logic [23:0] IDLE_CYCLES = 24'd5_000_000
) (
    input  logic        clk_sys,
    input  logic        RESET_n,
    input  logic        img_mounted,
    input  logic [31:0] img_size,
    input  logic        ioctl_download,
    input  logic        bk_save,
    input  logic        nvram_we,
    input  logic        sd_ack,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic        bk_ena,
    output logic        bk_busy,
    output logic        bk_reset
);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t             r_state;
    op_t                r_op;
    logic [BLK_W-1:0]   r_lba;
    logic               r_sd_rd;
    logic               r_sd_wr;
    logic               r_bk_ena;
    logic               r_bk_busy;
    logic               r_bk_reset;
    logic               r_pend_load;
    logic               r_pend_save;
    logic               r_abort;

    // Previous-cycle copies of the inputs for edge detection
    logic               r_mnt_old;
    logic               r_save_old;
    logic               r_dl_old;
    logic               r_ack_old;

    // ------------------------------------------------------------------
    // Edge detection: current input against its one-cycle-old copy, so a
    // rise is acted on at the first clock edge that sees the new level.
    // ------------------------------------------------------------------
    logic w_mnt_rise;
    logic w_save_rise;
    logic w_dl_rise;
    logic w_ack_rise;
    logic w_ack_fall;
    logic w_last_blk;

    assign w_mnt_rise  = img_mounted    & ~r_mnt_old;
    assign w_save_rise = bk_save        & ~r_save_old;
    assign w_dl_rise   = ioctl_download & ~r_dl_old;
    assign w_ack_rise  = sd_ack         & ~r_ack_old;
    assign w_ack_fall  = ~sd_ack        &  r_ack_old;
    assign w_last_blk  = &r_lba;

`ifdef BKRAM_AUTOSAVE_EN
    logic               r_dirty;
    logic [23:0]        r_quiet_cnt;
`else
    // Autosave disabled: the write strobe and quiet time are intentionally
    // left without a load.
    logic               w_unused_nvram_we;
    logic [23:0]        w_unused_idle_cycles;
    assign w_unused_nvram_we    = nvram_we;
    assign w_unused_idle_cycles = IDLE_CYCLES;
`endif

    // ------------------------------------------------------------------
    // Sequencer and request bookkeeping.
    // Statement order matters: the FSM clears a pending flag when it
    // takes it, a new rise in the same cycle sets it again afterwards,
    // and a download rise finally clears everything (download wins).
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (!RESET_n) begin
            r_state     <= IDLE;
            r_op        <= OP_LOAD;
            r_lba       <= '0;
            r_sd_rd     <= 1'b0;
            r_sd_wr     <= 1'b0;
            r_bk_ena    <= 1'b0;
            r_bk_busy   <= 1'b0;
            r_bk_reset  <= 1'b0;
            r_pend_load <= 1'b0;
            r_pend_save <= 1'b0;
            r_abort     <= 1'b0;
            r_mnt_old   <= 1'b0;
            r_save_old  <= 1'b0;
            r_dl_old    <= 1'b0;
            r_ack_old   <= 1'b0;
`ifdef BKRAM_AUTOSAVE_EN
            r_dirty     <= 1'b0;
            r_quiet_cnt <= '0;
`endif
        end else begin
            r_mnt_old  <= img_mounted;
            r_save_old <= bk_save;
            r_dl_old   <= ioctl_download;
            r_ack_old  <= sd_ack;
            r_bk_reset <= 1'b0;

            case (r_state)
                IDLE: begin
                    // A download starting this cycle cancels any pending
                    // work, so do not launch a sequence it would abort.
                    if (!w_dl_rise && (r_pend_load || r_pend_save)) begin
                        r_state   <= REQ;
                        r_lba     <= '0;
                        r_bk_busy <= 1'b1;
                        r_abort   <= 1'b0;
                        if (r_pend_load) begin
                            r_op        <= OP_LOAD;
                            r_sd_rd     <= 1'b1;
                            r_sd_wr     <= 1'b0;
                            r_pend_load <= 1'b0;
                        end else begin
                            r_op        <= OP_SAVE;
                            r_sd_rd     <= 1'b0;
                            r_sd_wr     <= 1'b1;
                            r_pend_save <= 1'b0;
                        end
                    end
                end

                REQ: begin
                    // Requests stay up until user_io takes the block.
                    if (w_ack_rise) begin
                        r_sd_rd <= 1'b0;
                        r_sd_wr <= 1'b0;
                        r_state <= XFER;
                    end
                end

                XFER: begin
                    if (w_ack_fall) begin
                        if (r_abort) begin
                            // The block in flight finishes; stop here and
                            // leave sd_lba pointing at it.
                            r_state   <= IDLE;
                            r_bk_busy <= 1'b0;
                            r_abort   <= 1'b0;
                        end else if (w_last_blk) begin
                            r_state   <= IDLE;
                            r_bk_busy <= 1'b0;
                            if (r_op == OP_LOAD) begin
                                r_bk_reset <= 1'b1;
`ifdef BKRAM_AUTOSAVE_EN
                                r_dirty    <= 1'b0;
`endif
                            end
                        end else begin
                            r_lba   <= r_lba + 1'b1;
                            r_sd_rd <= (r_op == OP_LOAD);
                            r_sd_wr <= (r_op == OP_SAVE);
                            r_state <= REQ;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_sd_rd <= 1'b0;
                    r_sd_wr <= 1'b0;
                end
            endcase

            if (w_mnt_rise) begin
                if (img_size != 32'd0) begin
                    r_bk_ena    <= 1'b1;
                    r_pend_load <= 1'b1;
                end else begin
                    r_bk_ena    <= 1'b0;
                end
            end

            if (w_save_rise && r_bk_ena) begin
                r_pend_save <= 1'b1;
            end

`ifdef BKRAM_AUTOSAVE_EN
            // Every core write restarts the quiet window. The window only
            // counts down while no transfer is running, so a save never
            // starts in the middle of another sequence.
            if (nvram_we) begin
                r_dirty     <= 1'b1;
                r_quiet_cnt <= IDLE_CYCLES;
            end else if (r_state == IDLE) begin
                if (r_quiet_cnt != 24'd0) begin
                    r_quiet_cnt <= r_quiet_cnt - 1'b1;
                end else if (r_dirty && r_bk_ena) begin
                    r_pend_save <= 1'b1;
                    r_dirty     <= 1'b0;
                end
            end
`endif

            if (w_dl_rise) begin
                r_bk_ena    <= 1'b0;
                r_pend_load <= 1'b0;
                r_pend_save <= 1'b0;
                if (r_bk_busy) begin
                    r_abort <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all driven straight from registers)
    // ------------------------------------------------------------------
    assign sd_lba   = {{(32-BLK_W){1'b0}}, r_lba};
    assign sd_rd    = r_sd_rd;
    assign sd_wr    = r_sd_wr;
    assign bk_ena   = r_bk_ena;
    assign bk_busy  = r_bk_busy;
    assign bk_reset = r_bk_reset;

endmodule
`default_nettype wire

// File: tb/tb_bkram_sd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bkram_sd_ctrl
//  Description : Self-checking bench for bkram_sd_ctrl. A user_io block
//                responder acknowledges requests with random latency and
//                checks every request against an expected transaction
//                queue built from the backup rules (load = read blocks
//                0..15, save = write blocks 0..15).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bkram_sd_ctrl;

    localparam int NBLK = 16;

    logic        clk_sys = 1'b0;
    logic        RESET_n;
    logic        img_mounted;
    logic [31:0] img_size;
    logic        ioctl_download;
    logic        bk_save;
    logic        nvram_we;
    logic        sd_ack;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        bk_ena;
    logic        bk_busy;
    logic        bk_reset;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];          // expected requests: {op(1=save) << 16 | lba}
    int req_count = 0;
    int rst_cnt   = 0;
    bit slow      = 1'b0;

    always #5 clk_sys = ~clk_sys;

    bkram_sd_ctrl #(
        .BLK_W       (4),
        .IDLE_CYCLES (24'd100)
    ) u_dut (
        .clk_sys        (clk_sys),
        .RESET_n        (RESET_n),
        .img_mounted    (img_mounted),
        .img_size       (img_size),
        .ioctl_download (ioctl_download),
        .bk_save        (bk_save),
        .nvram_we       (nvram_we),
        .sd_ack         (sd_ack),
        .sd_lba         (sd_lba),
        .sd_rd          (sd_rd),
        .sd_wr          (sd_wr),
        .bk_ena         (bk_ena),
        .bk_busy        (bk_busy),
        .bk_reset       (bk_reset)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Continuous monitor: read and write never together, count bk_reset cycles.
    always @(negedge clk_sys) begin
        check_eq("rd_wr_exclusive", {31'd0, sd_rd & sd_wr}, 32'd0);
        if (bk_reset) rst_cnt++;
    end

    // user_io block responder / scoreboard
    initial begin : responder
        int e;
        int n;
        int d1;
        int d2;
        sd_ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (RESET_n && (sd_rd || sd_wr)) begin
                req_count++;
                check_eq("req_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("req_op", {31'd0, sd_wr}, (e >> 16) & 1);
                    check_eq("req_lba", sd_lba, e & 32'hFFFF);
                end
                d1 = slow ? 5 : $urandom_range(0, 3);
                d2 = slow ? 5 : $urandom_range(0, 3);
                repeat (d1) @(negedge clk_sys);
                sd_ack = 1'b1;
                n = 0;
                while ((sd_rd || sd_wr) && n < 50) begin
                    @(negedge clk_sys);
                    n++;
                end
                if (n >= 50) check_eq("req_drop_timeout", n, 0);
                repeat (d2) @(negedge clk_sys);
                sd_ack = 1'b0;
            end
        end
    end

    task automatic push_seq(input int op);
        for (int i = 0; i < NBLK; i++) exp_q.push_back((op << 16) | i);
    endtask

    task automatic pulse_mount(input logic [31:0] size);
        @(negedge clk_sys);
        img_size    = size;
        img_mounted = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk_sys);
        img_mounted = 1'b0;
    endtask

    task automatic pulse_save();
        @(negedge clk_sys);
        bk_save = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk_sys);
        bk_save = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        repeat (4) @(negedge clk_sys);
        n = 0;
        while ((bk_busy || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk_sys);
            n++;
        end
        if (n >= 3000) check_eq("idle_timeout", n, 0);
        repeat (20) @(negedge clk_sys);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        int  n;
        int  act;
        bit  model_ena;
        int  exp_rst;
        logic [31:0] sz;

        RESET_n        = 1'b0;
        img_mounted    = 1'b0;
        img_size       = 32'd0;
        ioctl_download = 1'b0;
        bk_save        = 1'b0;
        nvram_we       = 1'b0;
        repeat (4) @(negedge clk_sys);
        check_eq("rst_sd_lba",   sd_lba, 32'd0);
        check_eq("rst_sd_rd",    {31'd0, sd_rd}, 32'd0);
        check_eq("rst_sd_wr",    {31'd0, sd_wr}, 32'd0);
        check_eq("rst_bk_ena",   {31'd0, bk_ena}, 32'd0);
        check_eq("rst_bk_busy",  {31'd0, bk_busy}, 32'd0);
        check_eq("rst_bk_reset", {31'd0, bk_reset}, 32'd0);
        RESET_n = 1'b1;
        repeat (3) @(negedge clk_sys);

        // Full load on mount of an 8 KiB image
        rst_cnt = 0;
        push_seq(0);
        pulse_mount(32'd8192);
        wait_idle();
        check_eq("load_bk_ena",   {31'd0, bk_ena}, 32'd1);
        check_eq("load_bk_reset", rst_cnt, 1);
        check_eq("load_last_lba", sd_lba, 32'd15);
        check_eq("load_busy_end", {31'd0, bk_busy}, 32'd0);

        // Save: request appears two cycles after the bk_save rise
        rst_cnt = 0;
        push_seq(1);
        @(negedge clk_sys);
        bk_save = 1'b1;
        n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (!sd_wr && n < 20);
        bk_save = 1'b0;
        check_eq("save_latency", n, 2);
        wait_idle();
        check_eq("save_bk_reset", rst_cnt, 0);
        check_eq("save_busy_end", {31'd0, bk_busy}, 32'd0);
        check_eq("save_last_lba", sd_lba, 32'd15);

        // Download during the lba 5 write aborts after that block
        slow    = 1'b1;
        rst_cnt = 0;
        for (int i = 0; i <= 5; i++) exp_q.push_back((1 << 16) | i);
        n = req_count;
        pulse_save();
        act = 0;
        while (req_count < n + 6 && act < 2000) begin
            @(negedge clk_sys);
            act++;
        end
        if (act >= 2000) check_eq("abort_wait_timeout", act, 0);
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        repeat (3) @(negedge clk_sys);
        ioctl_download = 1'b0;
        wait_idle();
        repeat (30) @(negedge clk_sys);
        check_eq("abort_lba",     sd_lba, 32'd5);
        check_eq("abort_bk_ena",  {31'd0, bk_ena}, 32'd0);
        check_eq("abort_busy",    {31'd0, bk_busy}, 32'd0);
        check_eq("abort_bk_reset", rst_cnt, 0);
        slow = 1'b0;

        // Zero-size mount: disabled, save request ignored
        pulse_mount(32'd0);
        repeat (5) @(negedge clk_sys);
        check_eq("mount0_bk_ena", {31'd0, bk_ena}, 32'd0);
        pulse_save();
        repeat (30) @(negedge clk_sys);
        check_eq("mount0_busy", {31'd0, bk_busy}, 32'd0);

        // Save rise during load block 3: the save follows the load
        slow    = 1'b1;
        rst_cnt = 0;
        push_seq(0);
        push_seq(1);
        n = req_count;
        pulse_mount(32'd8192);
        act = 0;
        while (req_count < n + 4 && act < 2000) begin
            @(negedge clk_sys);
            act++;
        end
        if (act >= 2000) check_eq("chain_wait_timeout", act, 0);
        pulse_save();
        wait_idle();
        check_eq("chain_bk_reset", rst_cnt, 1);
        check_eq("chain_bk_ena",   {31'd0, bk_ena}, 32'd1);
        slow = 1'b0;

`ifndef BKRAM_AUTOSAVE_EN
        // Without autosave, core writes never start a save
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_sys);
            nvram_we = 1'b1;
            @(negedge clk_sys);
            nvram_we = 1'b0;
        end
        repeat (300) @(negedge clk_sys);
        check_eq("nvram_we_ignored", {31'd0, bk_busy}, 32'd0);
`endif

        // Randomized sequence of mounts and saves against the model
        model_ena = 1'b1;
        for (int it = 0; it < 14; it++) begin
            act     = $urandom_range(0, 2);
            exp_rst = 0;
            rst_cnt = 0;
            case (act)
                0: begin
                    sz = $urandom_range(1, 65536);
                    model_ena = 1'b1;
                    exp_rst   = 1;
                    push_seq(0);
                    pulse_mount(sz);
                end
                1: begin
                    model_ena = 1'b0;
                    pulse_mount(32'd0);
                end
                default: begin
                    if (model_ena) push_seq(1);
                    pulse_save();
                end
            endcase
            wait_idle();
            check_eq("rand_bk_ena",   {31'd0, bk_ena}, {31'd0, model_ena});
            check_eq("rand_bk_reset", rst_cnt, exp_rst);
        end

`ifdef BKRAM_AUTOSAVE_EN
        // Autosave: one write, then the quiet window expires
        push_seq(0);
        pulse_mount(32'd8192);
        wait_idle();
        push_seq(1);
        @(negedge clk_sys);
        nvram_we = 1'b1;
        n = 0;
        do begin
            @(negedge clk_sys);
            nvram_we = 1'b0;
            n++;
        end while (!sd_wr && n < 300);
        check_eq("autosave_latency", {31'd0, (n >= 99 && n <= 105)}, 32'd1);
        wait_idle();
        // Writes closer than the quiet window keep postponing the save
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_sys);
            nvram_we = 1'b1;
            @(negedge clk_sys);
            nvram_we = 1'b0;
            repeat (48) @(negedge clk_sys);
            check_eq("autosave_quiet", {31'd0, bk_busy}, 32'd0);
        end
        push_seq(1);
        wait_idle();
`endif

        check_eq("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
